mem_access_ctrl: RTL

Memory-stage access controller between the EX/MEM pipeline register and the MEM/WB register. It turns a load/store from EX/MEM into a request/acknowledge transaction on a variable-latency data memory, stalls the pipeline until the transaction completes, and returns load data. `rdata_o` drives MEM/WB's memory-data input and `stall_o` drives MEM/WB's stall input (and the upstream pipeline registers).

---
 rtl/mem_access_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: turns EX/MEM loads/stores into a req/ack
// transaction on a variable-latency data memory and stalls the pipeline until done.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 32'd1);

    state_e     state_q;
    logic [7:0] cnt_q;
    logic       req_s;

    assign req_s = MemRead_i | MemWrite_i;

    // Stall is gated by reset so every output reads 0 while reset is held.
    assign stall_o = rst_i & (((state_q == ST_IDLE) & req_s) | (state_q == ST_ACCESS));

    // Access FSM with registered memory-side outputs, load data and sticky error.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'd0;
            mem_wdata_o <= 32'd0;
            rdata_o     <= 32'd0;
            err_o       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_s) begin
                        mem_addr_o  <= addr_i;
                        mem_wdata_o <= wdata_i;
                        mem_we_o    <= MemWrite_i;
                        mem_req_o   <= 1'b1;
                        cnt_q       <= 8'd0;
                        state_q     <= ST_ACCESS;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    // Ack beats the timeout compare when both land in the same cycle.
                    if (mem_ack_i) begin
                        if (!mem_we_o) begin
                            rdata_o <= mem_rdata_i;
                        end else begin
                            rdata_o <= rdata_o;
                        end
                        mem_req_o <= 1'b0;
                        state_q   <= ST_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        if (!mem_we_o) begin
                            rdata_o <= ERR_DATA;
                        end else begin
                            rdata_o <= rdata_o;
                        end
                        mem_req_o <= 1'b0;
                        err_o     <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        cnt_q   <= cnt_q + 8'd1;
                        state_q <= ST_ACCESS;
                    end
                end
                ST_DONE: begin
                    // Inputs still hold the completed instruction here; never resample them.
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
